// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU flag indices, bias helper and result type
package fpu_pkg;

    localparam int FLAG_OVF  = 3;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_INX  = 1;
    localparam int FLAG_ZERO = 0;

    function automatic int exp_bias(input int size_exp);
        return (1 << (size_exp - 1)) - 1;
    endfunction

    // Single-precision packed result, shared with the adder normaliser
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic [3:0]  flags;
    } fp_result_t;

endpackage

// File: rtl/leading_zero_counter.sv
// rtl/leading_zero_counter.sv - combinational leading-zero count, 0..WIDTH
module leading_zero_counter #(
    parameter int WIDTH = 48
) (
    input  logic [WIDTH-1:0]               data,
    output logic [$clog2(WIDTH+1)-1:0]     count
);

    localparam int CW = $clog2(WIDTH + 1);

    // Scanning upward lets the highest set bit win
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) count = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/mult_norm_round.sv
// rtl/mult_norm_round.sv - 2-stage normalise, round-to-nearest-even and pack for the FPU multiplier
module mult_norm_round
    import fpu_pkg::*;
#(
    parameter int SIZE_MANTISSA = 24,
    parameter int SIZE_EXP      = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_sign,
    input  logic signed [SIZE_EXP+1:0]        in_exp,
    input  logic [2*SIZE_MANTISSA-1:0]        in_prod,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_sign,
    output logic [SIZE_EXP-1:0]               out_exp,
    output logic [SIZE_MANTISSA-2:0]          out_frac,
    output logic [3:0]                        out_flags,
    output logic [$clog2(2*SIZE_MANTISSA+1)-1:0] out_lzc
);

    localparam int PW = 2 * SIZE_MANTISSA;
    localparam int LW = $clog2(PW + 1);
    localparam int EW = SIZE_EXP + 3;
    localparam int FW = SIZE_MANTISSA - 1;
    localparam int GB = PW - SIZE_MANTISSA - 1;
    localparam logic signed [EW-1:0] EXP_INF = EW'(2 * exp_bias(SIZE_EXP) + 1);

    logic          s1_valid;
    logic          s1_sign;
    logic [PW-1:0] s1_sh;
    logic [EW-1:0] s1_e1;
    logic [LW-1:0] s1_lz;
    logic          s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    // Stage 1: count, shift and rebias
    logic [LW-1:0] lz;
    logic [PW-1:0] sh_next;
    logic [EW-1:0] e1_next;

    leading_zero_counter #(.WIDTH(PW)) u_lzc (
        .data  (in_prod),
        .count (lz)
    );

    assign sh_next = in_prod << lz;
    assign e1_next = {in_exp[SIZE_EXP+1], in_exp} + EW'(1) - {{(EW-LW){1'b0}}, lz};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sh    <= '0;
            s1_e1    <= '0;
            s1_lz    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_sh   <= sh_next;
                s1_e1   <= e1_next;
                s1_lz   <= lz;
            end
        end
    end

    // Stage 2: round to nearest even, then classify
    logic [FW-1:0] f;
    logic          g;
    logic          s;
    logic          rnd;
    logic [FW:0]   f_inc;
    logic [EW-1:0] e2;
    logic [SIZE_EXP-1:0] res_exp;
    logic [FW-1:0] res_frac;
    logic [3:0]    res_flags;

    assign f     = s1_sh[PW-2 -: FW];
    assign g     = s1_sh[GB];
    assign s     = |s1_sh[GB-1:0];
    assign rnd   = g && (s || f[0]);
    assign f_inc = {1'b0, f} + {{FW{1'b0}}, rnd};
    assign e2    = s1_e1 + {{(EW-1){1'b0}}, f_inc[FW]};

    always_comb begin
        res_exp   = '0;
        res_frac  = '0;
        res_flags = '0;
        if (!s1_sh[PW-1]) begin
            res_flags[FLAG_ZERO] = 1'b1;
        end else if ($signed(e2) >= EXP_INF) begin
            res_exp             = '1;
            res_flags[FLAG_OVF] = 1'b1;
            res_flags[FLAG_INX] = 1'b1;
        end else if ($signed(e2) <= $signed(EW'(0))) begin
            res_flags[FLAG_UNF] = 1'b1;
            res_flags[FLAG_INX] = 1'b1;
        end else begin
            res_exp             = e2[SIZE_EXP-1:0];
            res_frac            = f_inc[FW-1:0];
            res_flags[FLAG_INX] = g || s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_frac  <= '0;
            out_flags <= '0;
            out_lzc   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign  <= s1_sign;
                out_exp   <= res_exp;
                out_frac  <= res_frac;
                out_flags <= res_flags;
                out_lzc   <= s1_lz;
            end
        end
    end

endmodule

// File: tb/tb_mult_norm_round.sv
// tb/tb_mult_norm_round.sv - self-checking bench for mult_norm_round
module tb_mult_norm_round;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_ready, in_sign;
    logic signed [9:0]  in_exp;
    logic [47:0]        in_prod;
    logic               out_valid, out_ready, out_sign;
    logic [7:0]         out_exp;
    logic [22:0]        out_frac;
    logic [3:0]         out_flags;
    logic [5:0]         out_lzc;
    logic [41:0]        out_word;

    int total = 0;
    int bad   = 0;
    bit sb_en = 0;
    int n_out = 0;
    logic [41:0] exp_q[$];

    always #5 clk = ~clk;

    mult_norm_round #(.SIZE_MANTISSA(24), .SIZE_EXP(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_flags (out_flags),
        .out_lzc   (out_lzc)
    );

    assign out_word = {out_sign, out_exp, out_frac, out_flags, out_lzc};

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] prod;
        logic [41:0] expect_word;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: value-level rounding of the product to 24 significant bits
    function automatic logic [41:0] model(input logic s, input logic signed [9:0] e, input logic [47:0] p);
        int msb, lz, k, e1;
        longint unsigned m, keep, rem, half;
        msb = -1;
        for (int i = 0; i < 48; i++) if (p[i]) msb = i;
        if (msb < 0) return {s, 8'h00, 23'h0, 4'b0001, 6'd48};
        lz  = 47 - msb;
        m   = 64'(p);
        k   = msb - 23;
        rem = 0;
        if (k > 0) begin
            keep = m >> k;
            rem  = m & ((64'd1 << k) - 1);
            half = 64'd1 << (k - 1);
            if (rem > half || (rem == half && keep[0])) keep++;
        end else begin
            keep = m << (-k);
        end
        e1 = int'(e) + 1 - lz;
        if (keep == (64'd1 << 24)) begin
            keep = 64'd1 << 23;
            e1++;
        end
        if (e1 >= 255) return {s, 8'hFF, 23'h0, 4'b1010, 6'(lz)};
        if (e1 <= 0)   return {s, 8'h00, 23'h0, 4'b0110, 6'(lz)};
        return {s, 8'(e1), keep[22:0], 2'b00, rem != 0, 1'b0, 6'(lz)};
    endfunction

    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: got %h expected none", out_word);
                end else begin
                    chk("sb_result", out_word, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_sign, in_exp, in_prod));
        end
    end

    task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] p);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_prod  = p;
    endtask

    task automatic rand_drive();
        logic [47:0] p;
        int t;
        p = {16'($urandom), $urandom};
        p = p >> $urandom_range(0, 50);
        if ($urandom_range(0, 3) == 0) p[22:0] = 23'h400000;
        if ($urandom_range(0, 1) == 1) t = int'($urandom_range(0, 1023));
        else t = int'($urandom_range(0, 300)) - 20;
        drive(1'($urandom_range(0, 1)), t[9:0], p);
    endtask

    task automatic stream(input int n, input bit rand_ready);
        int  sent = 0;
        int  cyc  = 0;
        bit  holding = 0;
        while ((sent < n || exp_q.size() > 0) && cyc < 5000) begin
            @(posedge clk); #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sent < n) begin
                if (!holding) begin
                    if ($urandom_range(0, 4) != 0) begin
                        rand_drive();
                        holding = 1;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                holding = 0;
            end
            #2;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_complete", 64'(sent == n && exp_q.size() == 0), 64'd1);
    endtask

    vec_t tbl[7];
    vec_t bp[4];

    initial begin
        int sent, unstable, n0, stalls;
        bit have_snap;
        logic [41:0] snap;

        tbl[0] = '{1'b0, 10'd127, 48'h900000_000000, {1'b0, 8'd128, 23'h100000, 4'b0000, 6'd0}};
        tbl[1] = '{1'b0, 10'd127, 48'h7FFFFF_C00000, {1'b0, 8'd128, 23'h000000, 4'b0010, 6'd1}};
        tbl[2] = '{1'b0, 10'd254, 48'h800000_000000, {1'b0, 8'hFF, 23'h000000, 4'b1010, 6'd0}};
        tbl[3] = '{1'b1, 10'd0,   48'h400000_000000, {1'b1, 8'h00, 23'h000000, 4'b0110, 6'd1}};
        tbl[4] = '{1'b0, 10'd127, 48'h000000_000000, {1'b0, 8'h00, 23'h000000, 4'b0001, 6'd48}};
        tbl[5] = '{1'b0, 10'd10,  48'h800000_800000, {1'b0, 8'd11,  23'h000000, 4'b0010, 6'd0}};
        tbl[6] = '{1'b0, 10'd253, 48'h800000_000000, {1'b0, 8'hFE, 23'h000000, 4'b0000, 6'd0}};

        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_prod = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_outputs", 64'(out_word), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i].sign, tbl[i].exp, tbl[i].prod);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("tbl_latency_early", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            chk("tbl_out_valid", 64'(out_valid), 64'd1);
            chk($sformatf("tbl_vec%0d", i), 64'(out_word), 64'(tbl[i].expect_word));
        end

        // Backpressure: two beats fill the pipe, the third is refused
        foreach (bp[i]) bp[i] = '{1'($urandom), 10'($urandom_range(1, 250)), {16'($urandom), $urandom} | 48'h800000_000000, '0};
        sent = 0; unstable = 0; have_snap = 0; snap = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            sb_en = 1; out_ready = 1'b0;
            if (sent < 4) drive(bp[sent].sign, bp[sent].exp, bp[sent].prod);
            else in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) begin
                if (!have_snap) begin
                    snap = out_word;
                    have_snap = 1;
                end else if (out_word !== snap) begin
                    unstable++;
                end
            end
            if (in_valid && in_ready) sent++;
        end
        chk("bp_accepted", 64'(sent), 64'd2);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_out_stable", 64'(unstable), 64'd0);
        n0 = n_out;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            if (sent < 4) drive(bp[sent].sign, bp[sent].exp, bp[sent].prod);
            else in_valid = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            #1;
            if (sent == 4 && exp_q.size() == 0) break;
        end
        in_valid = 1'b0;
        chk("bp_drained", 64'(n_out - n0), 64'd4);

        stream(300, 1'b1);

        // Full throughput: no stall cycles under continuous out_ready
        stalls = 0;
        n0 = n_out;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            rand_drive();
            @(negedge clk);
            if (!in_ready) stalls++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("tput_stalls", 64'(stalls), 64'd0);
        chk("tput_outputs", 64'(n_out - n0), 64'd40);

        // Reset with two beats parked in the pipe
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            drive(tbl[0].sign, tbl[0].exp, tbl[0].prod);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_en = 0;
        chk("mid_pre_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_outputs", 64'(out_word), 64'd0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_no_ghost", 64'(out_valid), 64'd0);
        drive(tbl[3].sign, tbl[3].exp, tbl[3].prod);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_rst_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd1);
        chk("mid_rst_result", 64'(out_word), 64'(tbl[3].expect_word));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_norm_round.md
# mult_norm_round

Pipelined normalise-and-round stage for the FPU multiplier datapath. Accepts the raw double-width mantissa product and biased exponent sum from the multiplier array, counts leading zeros, shifts, rounds to nearest-even, and packs sign/exponent/fraction with IEEE-style exception flags. Generalises the single-cycle normaliser to any mantissa/exponent width and adds a valid/ready handshake, rounding, overflow/underflow handling and a fixed 2-cycle latency.

## Interface
- `SIZE_MANTISSA`, 24: mantissa width including the hidden bit. The product width is `PW = 2*SIZE_MANTISSA`.
- `SIZE_EXP`, 8: packed exponent width. Bias is `2^(SIZE_EXP-1)-1`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: the stage accepts a beat this cycle.
- `in_sign` in 1: product sign.
- `in_exp` in SIZE_EXP+2: signed biased exponent sum, `ea+eb-bias`.
- `in_prod` in PW: unsigned mantissa product. Bit PW-1 has weight 2^1.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_sign` out 1: result sign.
- `out_exp` out SIZE_EXP: packed exponent.
- `out_frac` out SIZE_MANTISSA-1: packed fraction, hidden bit dropped.
- `out_flags` out 4: the flags `{overflow, underflow, inexact, zero}`.
- `out_lzc` out $clog2(PW+1): leading-zero count used, for debug.

## Operation
- **Stage 1 (S1), capture and shift:**
  - `lz` = leading zeros of `in_prod`, in the range 0..PW. `lz = PW` when the product is zero.
  - `sh = in_prod << lz`.
  - `e1 = in_exp + 1 - lz`, signed, width SIZE_EXP+2+1.
- **Stage 2 (S2), round, adjust and pack:**
  - Fraction `f = sh[PW-2 -: SIZE_MANTISSA-1]`.
  - Guard `G = sh[PW-SIZE_MANTISSA-1]`.
  - Sticky `S` = OR of all lower bits.
  - Increment when `G & (S | f[0])`.
  - If the increment overflows `f`, then `f = 0` and `e1 = e1 + 1`.
- **Result cases, in priority order:**
  1. Zero product: exp 0, frac 0, `zero=1`. No other flags.
  2. `e1 >= 2^SIZE_EXP-1`: exp all ones, frac 0 (infinity), `overflow=1`, `inexact=1`.
  3. `e1 <= 0`: flush to signed zero, `underflow=1`, `inexact=1`.
  4. Otherwise: `out_exp = e1[SIZE_EXP-1:0]`, `out_frac = f`, `inexact = G|S`.
- `out_sign = in_sign` in every case.

## Timing
- **Reset values** (asynchronous, while `rst_n=0`):
  - `out_valid=0`.
  - `out_sign`, `out_exp`, `out_frac`, `out_flags`, `out_lzc` all 0.
  - Both stage-valid registers 0.
  - `in_ready=1` from the first cycle after release.
- **Handshake:**
  - A beat transfers when `valid & ready` on a rising edge.
  - `s2_adv = !out_valid | out_ready`.
  - `in_ready = !s1_valid | s2_adv`. This is a combinational path from `out_ready`, which is permitted.
- **Latency and throughput:** 2 cycles from input acceptance to `out_valid`, at 1 beat per cycle with no bubbles under continuous `out_ready`.
- **Backpressure:**
  - While `out_valid & !out_ready`, all `out_*` hold stable and S1 holds.
  - At most 2 beats are in flight. The third is refused with `in_ready=0`.
- **Simultaneous events:** an S2 drain and an S1 refill in the same cycle are legal and lose no beat.
- **Reset mid-operation:** in-flight beats are discarded. `out_valid` drops asynchronously.
- **Width rules:** all exponent arithmetic is signed SIZE_EXP+3 bits and never wraps. `lz` is zero-extended before subtraction.

## Structure
- **Shared package `fpu_pkg`:**
  - Flag bit indices `FLAG_OVF=3`, `FLAG_UNF=2`, `FLAG_INX=1`, `FLAG_ZERO=0`.
  - Function `exp_bias(SIZE_EXP)`.
  - The packed result struct typedef, reused by the adder normaliser.
- **Sub-module `leading_zero_counter #(WIDTH)`:** combinational LZC, outputs 0..WIDTH, instantiated in S1. It replaces the hand-written casex priority tree.

## Test plan
All vectors use default parameters.
- **Simple normalise:** `in_prod=48'h900000_000000` (1.5×1.5), `in_exp=127`, sign 0 → after 2 cycles `out_exp=128`, `out_frac=23'h100000`, `out_lzc=0`, flags 0.
- **Rounding with mantissa carry-out:** `in_prod=48'h7FFFFF_C00000`, `in_exp=127` → `lz=1` and a tie with `f[0]=1` rounds up and carries → `out_exp=128`, `out_frac=0`, `inexact=1`.
- **Overflow:** `in_exp=254`, `in_prod=48'h800000_000000` → `out_exp=8'hFF`, `out_frac=0`, `overflow=1`, `inexact=1`.
- **Underflow and zero:**
  - `in_exp=0`, `in_prod=48'h400000_000000`, sign 1 → exp 0, frac 0, `out_sign=1`, `underflow=1`.
  - `in_prod=0` → `zero=1` only, `out_lzc=48`.
- **Backpressure:** 4 back-to-back beats with `out_ready=0` for 5 cycles → `in_ready` falls after 2 accepted beats. Outputs stay stable. After `out_ready=1`, all 4 results emerge in order with no loss or duplication.
- **Reset mid-operation:** assert `rst_n=0` with 2 beats in flight, mid-cycle → `out_valid=0` immediately, all outputs 0. After release, the first new beat appears exactly 2 cycles after acceptance.
